// File: rtl/leds_racer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : leds_racer_pkg
//  Description : Shared types and constants for the LED racer frame path:
//                sequencer state encoding, pixel width and GRB packing order.
//  Revision    : 1.0 - initial release
// ============================================================================
package leds_racer_pkg;

  localparam int PIXEL_W = 24;
  localparam int CHAN_W  = 8;

  // Sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ADDR       = 3'd1,
    S_SETTLE     = 3'd2,
    S_PRESENT    = 3'd3,
    S_LATCH_REQ  = 3'd4,
    S_LATCH_WAIT = 3'd5
  } seq_state_t;

  // Strip wire order: green first (MSB), then red, then blue
  function automatic logic [PIXEL_W-1:0] pack_grb(
    input logic [CHAN_W-1:0] g,
    input logic [CHAN_W-1:0] r,
    input logic [CHAN_W-1:0] b
  );
    return {g, r, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_frame_sequencer_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module      : refresh_timer
//  Description : Free-running down-counter that forces periodic frame
//                refreshes. Reloads on 'load' or after reaching zero;
//                'expired' is high for the single cycle the count is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module refresh_timer
  import leds_racer_pkg::*;
#(
  parameter int REFRESH_CLK_COUNT = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int c_CNT_W = (REFRESH_CLK_COUNT > 1) ? $clog2(REFRESH_CLK_COUNT) : 1;
  localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(REFRESH_CLK_COUNT - 1);

  logic [c_CNT_W-1:0] r_count;

  assign expired = (r_count == '0);

  // Count down; restart the period on frame start or when the period elapses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= c_RELOAD;
    end else if (load || expired) begin
      r_count <= c_RELOAD;
    end else begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_frame_sequencer
//  Description : Walks current_led over the strip, captures the core's GRB
//                intensities after a settle latency, hands each pixel to the
//                serializer over valid/ready and requests the strip latch.
//                Frame requests arriving mid-frame coalesce into one extra
//                frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_frame_sequencer
  import leds_racer_pkg::*;
#(
  parameter int MAX_POS           = 16,
  parameter int PIX_LATENCY       = 1,
  parameter int REFRESH_CLK_COUNT = 833333
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       update_frame,
  input  logic [CHAN_W-1:0]          led_green_intensity,
  input  logic [CHAN_W-1:0]          led_red_intensity,
  input  logic [CHAN_W-1:0]          led_blue_intensity,
  output logic [$clog2(MAX_POS)-1:0] current_led,
  output logic [PIXEL_W-1:0]         pixel_data,
  output logic                       pixel_valid,
  input  logic                       pixel_ready,
  output logic                       frame_latch,
  input  logic                       latch_done,
  output logic                       frame_busy
);

  localparam int                 c_IDX_W       = $clog2(MAX_POS);
  localparam logic [c_IDX_W-1:0] c_LAST_LED    = c_IDX_W'(MAX_POS - 1);
  localparam bit                 c_NO_SETTLE   = (PIX_LATENCY == 0);
  localparam logic [2:0]         c_SETTLE_INIT = 3'((PIX_LATENCY > 0) ? PIX_LATENCY - 1 : 0);

  seq_state_t           r_state;
  logic [c_IDX_W-1:0]   r_led;
  logic [PIXEL_W-1:0]   r_data;
  logic                 r_valid;
  logic                 r_latch;
  logic                 r_busy;
  logic                 r_pending;
  logic [2:0]           r_settle;

  logic                 w_expired;
  logic                 w_start;
  logic                 w_load;
  logic [PIXEL_W-1:0]   w_pixel;

  assign w_start = update_frame | r_pending | w_expired;
  assign w_load  = (r_state == S_IDLE) && w_start;
  assign w_pixel = pack_grb(led_green_intensity, led_red_intensity, led_blue_intensity);

  refresh_timer #(
    .REFRESH_CLK_COUNT(REFRESH_CLK_COUNT)
  ) u_refresh_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .expired(w_expired)
  );

  // Frame FSM with index counter, settle counter, capture register and flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_led     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_latch   <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= 1'b0;
      r_settle  <= '0;
    end else begin
      r_latch <= 1'b0;
      // Any request seen while a frame is running folds into one extra frame
      if (r_busy && (update_frame || w_expired)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_led     <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (c_NO_SETTLE) begin
            r_data  <= w_pixel;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end else begin
            r_settle <= c_SETTLE_INIT;
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle == '0) begin
            r_data  <= w_pixel;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        S_PRESENT: begin
          if (pixel_ready) begin
            r_valid <= 1'b0;
            if (r_led == c_LAST_LED) begin
              r_latch <= 1'b1;
              r_state <= S_LATCH_REQ;
            end else begin
              r_led   <= r_led + 1'b1;
              r_state <= S_ADDR;
            end
          end
        end
        S_LATCH_REQ: begin
          r_state <= S_LATCH_WAIT;
        end
        S_LATCH_WAIT: begin
          if (latch_done) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign current_led = r_led;
  assign pixel_data  = r_data;
  assign pixel_valid = r_valid;
  assign frame_latch = r_latch;
  assign frame_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_frame_sequencer
//  Description : Scoreboard bench for led_frame_sequencer. Stimulus pushes
//                the pixels each frame must deliver; a negedge monitor pops
//                them on every transfer and checks latch/stall behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_frame_sequencer;

  localparam int MAX_POS     = 4;
  localparam int PIX_LATENCY = 1;
  localparam int REFRESH     = 1000;
  localparam int IDX_W       = $clog2(MAX_POS);
  localparam int FRAME_CYC   = MAX_POS * (2 + PIX_LATENCY) + 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             update_frame = 1'b0;
  logic             pixel_ready = 1'b1;
  logic             latch_done = 1'b1;
  logic [7:0]       led_green_intensity, led_red_intensity, led_blue_intensity;
  logic [IDX_W-1:0] current_led;
  logic [23:0]      pixel_data;
  logic             pixel_valid, frame_latch, frame_busy;

  always #5 clk = ~clk;

  led_frame_sequencer #(
    .MAX_POS(MAX_POS), .PIX_LATENCY(PIX_LATENCY), .REFRESH_CLK_COUNT(REFRESH)
  ) dut (
    .clk(clk), .reset(reset), .update_frame(update_frame),
    .led_green_intensity(led_green_intensity), .led_red_intensity(led_red_intensity),
    .led_blue_intensity(led_blue_intensity), .current_led(current_led),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .frame_latch(frame_latch), .latch_done(latch_done), .frame_busy(frame_busy)
  );

  // Core model: per-LED GRB table, answers with one cycle of latency
  logic [23:0] core_tab [MAX_POS];
  logic [23:0] core_q;
  always_ff @(posedge clk) core_q <= core_tab[current_led];
  assign {led_green_intensity, led_red_intensity, led_blue_intensity} = core_q;

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [23:0]      data;
    logic [IDX_W-1:0] led;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;

  logic rand_ready = 1'b0;
  logic rand_done  = 1'b0;

  // One full frame from the current core table: every LED in order
  task automatic push_frame();
    for (int i = 0; i < MAX_POS; i++) exp_q.push_back({core_tab[i], IDX_W'(i)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) pixel_ready = ($urandom_range(0, 3) != 0);
    if (rand_done)  latch_done  = ($urandom_range(0, 2) == 0);
  endtask

  task automatic request();
    update_frame = 1'b1;
    step();
    update_frame = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || frame_busy) && n < 3000) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()) | 32'(frame_busy), 32'd0);
  endtask

  // Monitor: transfers against the scoreboard, stall stability, latch rules
  int          latch_cnt = 0;
  int          frame_pix = 0;
  int          last_xfer = -10;
  logic        prev_stall = 1'b0;
  logic        prev_latch = 1'b0;
  logic [23:0] prev_data;
  logic [IDX_W-1:0] prev_led;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
      prev_latch = 1'b0;
      frame_pix  = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(pixel_valid), 32'd1);
        check("stall_data", 32'(pixel_data), 32'(prev_data));
        check("stall_led", 32'(current_led), 32'(prev_led));
      end
      if (pixel_valid && pixel_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("pixel_data", 32'(pixel_data), 32'(mon_e.data));
          check("pixel_led", 32'(current_led), 32'(mon_e.led));
        end
        frame_pix++;
        last_xfer = cyc;
      end
      if (frame_latch) begin
        check("latch_single", 32'(prev_latch), 32'd0);
        check("latch_pixels", 32'(frame_pix), 32'(MAX_POS));
        check("latch_after_last", 32'(cyc - last_xfer), 32'd1);
        latch_cnt++;
        frame_pix = 0;
      end
      prev_stall = pixel_valid && !pixel_ready;
      prev_data  = pixel_data;
      prev_led   = current_led;
      prev_latch = frame_latch;
    end
  end

  initial begin
    int   n, lc, k;
    logic held;

    for (int i = 0; i < MAX_POS; i++) core_tab[i] = {8'(i), 8'(i + 1), 8'(i + 2)};

    // Reset values
    #2 reset = 1'b0;
    #1;
    check("rst_led", 32'(current_led), 32'd0);
    check("rst_data", 32'(pixel_data), 32'd0);
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_latch", 32'(frame_latch), 32'd0);
    check("rst_busy", 32'(frame_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Timer-driven first frame, ready and latch_done tied high
    push_frame();
    repeat (REFRESH - 1) step();
    check("timer_not_yet", 32'(frame_busy), 32'd0);
    step();
    check("timer_start", 32'(frame_busy), 32'd1);
    n = 1;
    while (frame_busy && n < 100) begin
      step();
      if (frame_busy) n++;
    end
    check("busy_cycles", 32'(n), 32'(FRAME_CYC));
    check("timer_latches", 32'(latch_cnt), 32'd1);
    check("timer_queue", 32'(exp_q.size()), 32'd0);

    // update_frame pulse: start latency and first-pixel latency
    repeat (2) step();
    push_frame();
    request();
    check("start_busy", 32'(frame_busy), 32'd1);
    for (int i = 1; i < 2 + PIX_LATENCY; i++) begin
      check("valid_early", 32'(pixel_valid), 32'd0);
      step();
    end
    check("valid_rise", 32'(pixel_valid), 32'd1);
    wait_done("pattern_done");

    // Stall on pixel 2 for five cycles
    push_frame();
    request();
    n = 0;
    while (!(pixel_valid && current_led == 2) && n < 100) begin
      step();
      n++;
    end
    check("reach_led2", 32'(pixel_valid && current_led == 2), 32'd1);
    pixel_ready = 1'b0;
    repeat (5) begin
      step();
      check("stall_hold_led2", 32'(current_led), 32'd2);
    end
    pixel_ready = 1'b1;
    wait_done("stall_done");

    // Three requests during a frame coalesce into exactly one more
    lc = latch_cnt;
    push_frame();
    push_frame();
    request();
    repeat (3) begin
      repeat (2) step();
      request();
    end
    n = 0;
    while (frame_busy && n < 100) begin
      step();
      n++;
    end
    step();
    check("coalesced_start", 32'(frame_busy), 32'd1);
    wait_done("coalesce_done");
    repeat (6) step();
    check("no_third_frame", 32'(frame_busy), 32'd0);
    check("coalesce_latches", 32'(latch_cnt - lc), 32'd2);

    // Delayed latch_done: busy held, single latch pulse
    lc = latch_cnt;
    latch_done = 1'b0;
    push_frame();
    request();
    n = 0;
    while (!frame_latch && n < 100) begin
      step();
      n++;
    end
    check("latch_seen", 32'(frame_latch), 32'd1);
    held = 1'b1;
    repeat (20) begin
      step();
      if (!frame_busy) held = 1'b0;
    end
    check("busy_held", 32'(held), 32'd1);
    latch_done = 1'b1;
    step();
    check("busy_fall", 32'(frame_busy), 32'd0);
    check("delay_latches", 32'(latch_cnt - lc), 32'd1);

    // Reset while presenting LED 1
    step();
    push_frame();
    request();
    n = 0;
    while (!(pixel_valid && current_led == 1) && n < 100) begin
      step();
      n++;
    end
    check("reach_led1", 32'(pixel_valid && current_led == 1), 32'd1);
    pixel_ready = 1'b0;
    lc = latch_cnt;
    #1 reset = 1'b0;
    #1;
    check("mid_rst_led", 32'(current_led), 32'd0);
    check("mid_rst_data", 32'(pixel_data), 32'd0);
    check("mid_rst_valid", 32'(pixel_valid), 32'd0);
    check("mid_rst_busy", 32'(frame_busy), 32'd0);
    check("mid_rst_latch", 32'(frame_latch), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    pixel_ready = 1'b1;
    repeat (3) step();
    check("abort_no_latch", 32'(latch_cnt - lc), 32'd0);
    push_frame();
    request();
    check("restart_led0", 32'(current_led), 32'd0);
    wait_done("restart_done");

    // Randomized frames: random core data, stalls, latch delays, extra requests
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < MAX_POS; i++) core_tab[i] = 24'($urandom);
      rand_ready = 1'b1;
      rand_done  = 1'b1;
      k = $urandom_range(0, 3);
      push_frame();
      request();
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(1, 2)) step();
        request();
      end
      if (k > 0) push_frame();
      wait_done("random_done");
      rand_ready  = 1'b0;
      rand_done   = 1'b0;
      pixel_ready = 1'b1;
      latch_done  = 1'b1;
      step();
    end

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
